vec_inst_queue: RTL

Parametrised instruction/operand queue between the scalar processor and the vector processor. It buffers instruction, rs1_data and rs2_data triples through an independent valid/ready handshake on each side. Depth is configurable to any value of 2 or more, with an optional empty-queue bypass, a synchronous flush and occupancy/almost-full status. It replaces the fixed two-entry queue in front of the datapath and controller.

---
 rtl/vec_queue_pkg.sv | 21 ++
 rtl/vec_queue_mem.sv | 28 ++
 rtl/vec_inst_queue.sv | 120 ++++++++++++
 3 files changed

// File: rtl/vec_queue_pkg.sv
// Shared entry type and sizing helper for the
// scalar-to-vector instruction queue.
`ifndef XLEN
`define XLEN 32
`endif

package vec_queue_pkg;

    localparam int VQ_XLEN = `XLEN;

    typedef struct packed {
        logic [VQ_XLEN-1:0] instruction;
        logic [VQ_XLEN-1:0] rs1_data;
        logic [VQ_XLEN-1:0] rs2_data;
    } vec_inst_entry_t;

    function automatic int cnt_width(input int depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/vec_queue_mem.sv
// Entry storage: one synchronous write port,
// one asynchronous read port, no reset.
module vec_queue_mem
    import vec_queue_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int AW    = $clog2(DEPTH),
    parameter int EW    = $bits(vec_inst_entry_t)
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [EW-1:0] wdata,
    input  logic [AW-1:0] raddr,
    output logic [EW-1:0] rdata
);

    vec_inst_entry_t mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/vec_inst_queue.sv
// Instruction/operand queue from the scalar core
// to the vector unit, with optional empty bypass.
module vec_inst_queue
    import vec_queue_pkg::*;
#(
    parameter int XLEN      = VQ_XLEN,
    parameter int DEPTH     = 4,
    parameter bit BYPASS_EN = 1'b1,
    parameter int AF_THRESH = DEPTH - 1
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       flush,
    input  logic                       inst_valid,
    output logic                       inst_ready,
    input  logic [XLEN-1:0]            instruction,
    input  logic [XLEN-1:0]            rs1_data,
    input  logic [XLEN-1:0]            rs2_data,
    output logic                       deq_valid,
    input  logic                       deq_ready,
    output logic [XLEN-1:0]            deq_instruction,
    output logic [XLEN-1:0]            deq_rs1_data,
    output logic [XLEN-1:0]            deq_rs2_data,
    output logic [$clog2(DEPTH+1)-1:0] count,
    output logic                       empty,
    output logic                       full,
    output logic                       almost_full
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = cnt_width(DEPTH);
    localparam int EW = $bits(vec_inst_entry_t);

    localparam logic [AW-1:0] LAST_PTR = AW'(DEPTH - 1);
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);
    localparam logic [CW-1:0] AF_CNT   = CW'(AF_THRESH);

    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;

    vec_inst_entry_t in_e;
    vec_inst_entry_t mem_e;
    vec_inst_entry_t head_e;

    logic blocked;
    logic enq;
    logic deq;
    logic bypass;
    logic wr_en;
    logic rd_en;

    assign in_e = {instruction, rs1_data, rs2_data};

    assign empty       = (count == '0);
    assign full        = (count == FULL_CNT);
    assign almost_full = (count >= AF_CNT);

    assign blocked    = reset || flush;
    assign inst_ready = !full && !blocked;

    // Bypass only applies to an empty queue; otherwise head comes from storage.
    always_comb begin
        deq_valid = 1'b0;
        head_e    = mem_e;
        if (!blocked) begin
            if (!empty) begin
                deq_valid = 1'b1;
            end else if (BYPASS_EN) begin
                deq_valid = inst_valid;
            end
        end
        if (empty && BYPASS_EN) begin
            head_e = in_e;
        end
    end

    assign deq_instruction = head_e.instruction;
    assign deq_rs1_data    = head_e.rs1_data;
    assign deq_rs2_data    = head_e.rs2_data;

    assign enq    = inst_valid && inst_ready;
    assign deq    = deq_valid && deq_ready;
    assign bypass = BYPASS_EN && empty && enq && deq;
    assign wr_en  = enq && !bypass;
    assign rd_en  = deq && !empty;

    always_ff @(posedge clk) begin
        if (blocked) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (wr_en) begin
                wr_ptr <= (wr_ptr == LAST_PTR) ? '0 : wr_ptr + 1'b1;
            end
            if (rd_en) begin
                rd_ptr <= (rd_ptr == LAST_PTR) ? '0 : rd_ptr + 1'b1;
            end
            case ({wr_en, rd_en})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    vec_queue_mem #(
        .DEPTH (DEPTH),
        .AW    (AW),
        .EW    (EW)
    ) u_mem (
        .clk   (clk),
        .we    (wr_en),
        .waddr (wr_ptr),
        .wdata (in_e),
        .raddr (rd_ptr),
        .rdata (mem_e)
    );

endmodule
